// File: rtl/gb_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gb_bus_pkg
//  Description : Shared constants, DMA state encoding and source-remap helper
//                for the Game Boy system bus / OAM DMA slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package gb_bus_pkg;

  // Memory-map landmarks decoded on the CPU address.
  localparam logic [15:0] ADDR_DMA    = 16'hFF46;
  localparam logic [15:0] HRAM_LO     = 16'hFF80;
  localparam logic [15:0] HRAM_HI     = 16'hFFFE;

  // OAM destination page and transfer length.
  localparam logic [7:0]  OAM_BASE_HI = 8'hFE;
  localparam int          OAM_LEN     = 160;

  // DMA engine states.
  typedef enum logic [1:0] {
    DMA_IDLE  = 2'd0,
    DMA_DELAY = 2'd1,
    DMA_XFER  = 2'd2
  } dma_state_e;

  // Sources E0..FF alias onto work RAM C0..DF, so bit 5 is dropped there.
  function automatic logic [7:0] src_remap(input logic [7:0] src);
    return (src >= 8'hE0) ? {src[7:6], 1'b0, src[4:0]} : src;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gb_dma_engine.sv
`default_nettype none
// ============================================================================
//  Module      : gb_dma_engine
//  Description : OAM DMA engine. Holds the FF46 source register, the start
//                delay counter, byte index / phase counters and the data latch,
//                and issues the read/write bus cycles of a 160-byte copy.
//  Revision    : 1.0 - initial release
// ============================================================================
module gb_dma_engine
  import gb_bus_pkg::*;
#(
  parameter int CYCLES_PER_BYTE = 4,
  parameter int START_DELAY     = 4
) (
  input  logic        clock4,
  input  logic        resetn,
  input  logic        start_i,       // CPU store to FF46 this cycle
  input  logic [7:0]  start_data_i,  // new source page
  input  logic [7:0]  mem_indata_i,  // same-cycle main bus read data
  output logic        active_o,      // engine owns the main bus
  output logic [15:0] addr_o,
  output logic [7:0]  data_o,
  output logic        load_o,
  output logic        store_o,
  output logic [7:0]  src_o
);

  localparam int CW = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
  localparam int PW = $clog2(CYCLES_PER_BYTE);

  localparam logic [CW-1:0] DELAY_INIT = CW'(START_DELAY - 1);
  localparam logic [PW-1:0] LAST_PHASE = PW'(CYCLES_PER_BYTE - 1);
  localparam logic [7:0]    LAST_IDX   = 8'(OAM_LEN - 1);

  dma_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic [7:0]      idx_q,   idx_d;
  logic [PW-1:0]   phase_q, phase_d;
  logic [7:0]      src_q,   src_d;
  logic [7:0]      latch_q, latch_d;

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clock4 or negedge resetn) begin
    if (!resetn) begin
      state_q <= DMA_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      phase_q <= '0;
      src_q   <= 8'hFF;
      latch_q <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      phase_q <= phase_d;
      src_q   <= src_d;
      latch_q <= latch_d;
    end
  end

  // Next-state and bus-cycle generation; a start always wins and suppresses
  // whatever access the engine would otherwise have made this cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    phase_d = phase_q;
    src_d   = src_q;
    latch_d = latch_q;
    addr_o  = {src_remap(src_q), idx_q};
    data_o  = latch_q;
    load_o  = 1'b0;
    store_o = 1'b0;

    if (start_i) begin
      src_d   = start_data_i;
      state_d = DMA_DELAY;
      cnt_d   = DELAY_INIT;
      idx_d   = '0;
      phase_d = '0;
    end else begin
      case (state_q)
        DMA_IDLE: begin
        end
        DMA_DELAY: begin
          if (cnt_q == '0) begin
            state_d = DMA_XFER;
            idx_d   = '0;
            phase_d = '0;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        DMA_XFER: begin
          if (phase_q == '0) begin
            addr_o  = {src_remap(src_q), idx_q};
            load_o  = 1'b1;
            latch_d = mem_indata_i;
          end else if (phase_q == PW'(1)) begin
            addr_o  = {OAM_BASE_HI, idx_q};
            store_o = 1'b1;
          end
          if (phase_q == LAST_PHASE) begin
            phase_d = '0;
            if (idx_q == LAST_IDX) begin
              state_d = DMA_IDLE;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + 8'd1;
            end
          end else begin
            phase_d = phase_q + PW'(1);
          end
        end
        default: begin
          state_d = DMA_IDLE;
        end
      endcase
    end
  end

  assign active_o = (state_q != DMA_IDLE);
  assign src_o    = src_q;

endmodule
`default_nettype wire

// File: rtl/gb_dma_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : gb_dma_arbiter
//  Description : Shares the main memory bus between the CPU and the OAM DMA
//                engine, decodes FF46 and HRAM, and keeps HRAM reachable
//                while a DMA transfer blocks the rest of the map.
//  Revision    : 1.0 - initial release
// ============================================================================
module gb_dma_arbiter
  import gb_bus_pkg::*;
#(
  parameter int CYCLES_PER_BYTE = 4,
  parameter int START_DELAY     = 4
) (
  input  logic        clock4,
  input  logic        resetn,
  input  logic [15:0] cpu_address,
  input  logic [7:0]  cpu_outdata,
  input  logic        cpu_load,
  input  logic        cpu_store,
  output logic [7:0]  cpu_indata,
  output logic [15:0] mem_address,
  output logic [7:0]  mem_outdata,
  output logic        mem_load,
  output logic        mem_store,
  input  logic [7:0]  mem_indata,
  output logic [6:0]  hram_address,
  output logic [7:0]  hram_outdata,
  output logic        hram_load,
  output logic        hram_store,
  input  logic [7:0]  hram_indata,
  output logic        dma_active
);

  logic        is_hram, is_dmareg, is_main;
  logic        cpu_rd, cpu_wr, dma_start;
  logic        eng_active, eng_load, eng_store;
  logic [15:0] eng_addr;
  logic [7:0]  eng_data, eng_src;

  // Address decode; a simultaneous load and store is taken as a store, and
  // no CPU strobe propagates while reset is held.
  always_comb begin
    is_hram   = (cpu_address >= HRAM_LO) && (cpu_address <= HRAM_HI);
    is_dmareg = (cpu_address == ADDR_DMA);
    is_main   = !is_hram && !is_dmareg;
    cpu_wr    = resetn && cpu_store;
    cpu_rd    = resetn && cpu_load && !cpu_store;
    dma_start = is_dmareg && cpu_wr;
  end

  gb_dma_engine #(
    .CYCLES_PER_BYTE (CYCLES_PER_BYTE),
    .START_DELAY     (START_DELAY)
  ) u_engine (
    .clock4       (clock4),
    .resetn       (resetn),
    .start_i      (dma_start),
    .start_data_i (cpu_outdata),
    .mem_indata_i (mem_indata),
    .active_o     (eng_active),
    .addr_o       (eng_addr),
    .data_o       (eng_data),
    .load_o       (eng_load),
    .store_o      (eng_store),
    .src_o        (eng_src)
  );

  // Main bus and CPU read-data muxing: the engine owns the bus whenever it
  // is not idle, and blocked CPU reads of the main map float to FF.
  always_comb begin
    mem_address = cpu_address;
    mem_outdata = cpu_outdata;
    mem_load    = 1'b0;
    mem_store   = 1'b0;
    if (eng_active) begin
      mem_address = eng_addr;
      mem_outdata = eng_data;
      mem_load    = eng_load;
      mem_store   = eng_store;
    end else if (is_main) begin
      mem_load  = cpu_rd;
      mem_store = cpu_wr;
    end

    if (is_hram) begin
      cpu_indata = hram_indata;
    end else if (is_dmareg) begin
      cpu_indata = eng_src;
    end else if (eng_active) begin
      cpu_indata = 8'hFF;
    end else begin
      cpu_indata = mem_indata;
    end
  end

  assign hram_address = cpu_address[6:0];
  assign hram_outdata = cpu_outdata;
  assign hram_load    = is_hram && cpu_rd;
  assign hram_store   = is_hram && cpu_wr;
  assign dma_active   = eng_active;

endmodule
`default_nettype wire

// File: tb/tb_gb_dma_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gb_dma_arbiter
//  Description : Scoreboard bench for gb_dma_arbiter. The driver predicts
//                every main-bus cycle (CPU or DMA) into a queue; a monitor on
//                the falling edge pops and compares each strobe it sees.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gb_dma_arbiter;

  localparam int SD     = 4;
  localparam int CPB    = 4;
  localparam int NBYTES = 160;
  localparam int BUSY   = SD + NBYTES * CPB;
  localparam logic [15:0] A_DMA = 16'hFF46;

  logic        clock4 = 1'b0;
  logic        resetn = 1'b0;
  logic [15:0] cpu_address = 16'h0000;
  logic [7:0]  cpu_outdata = 8'h00;
  logic        cpu_load = 1'b0;
  logic        cpu_store = 1'b0;
  logic [7:0]  cpu_indata;
  logic [15:0] mem_address;
  logic [7:0]  mem_outdata;
  logic        mem_load, mem_store;
  logic [7:0]  mem_indata;
  logic [6:0]  hram_address;
  logic [7:0]  hram_outdata;
  logic        hram_load, hram_store;
  logic [7:0]  hram_indata = 8'h00;
  logic        dma_active;

  logic [7:0]  mem_arr [0:65535];
  assign mem_indata = mem_arr[mem_address];

  gb_dma_arbiter #(.CYCLES_PER_BYTE(CPB), .START_DELAY(SD)) dut (
    .clock4       (clock4),
    .resetn       (resetn),
    .cpu_address  (cpu_address),
    .cpu_outdata  (cpu_outdata),
    .cpu_load     (cpu_load),
    .cpu_store    (cpu_store),
    .cpu_indata   (cpu_indata),
    .mem_address  (mem_address),
    .mem_outdata  (mem_outdata),
    .mem_load     (mem_load),
    .mem_store    (mem_store),
    .mem_indata   (mem_indata),
    .hram_address (hram_address),
    .hram_outdata (hram_outdata),
    .hram_load    (hram_load),
    .hram_store   (hram_store),
    .hram_indata  (hram_indata),
    .dma_active   (dma_active)
  );

  always #5 clock4 = ~clock4;

  int cyc = 0;
  always @(posedge clock4) cyc <= cyc + 1;

  // ---------------- reference model state ----------------
  typedef struct {
    int          cyc;
    bit          st;
    logic [15:0] addr;
    logic [7:0]  data;
  } ev_t;

  ev_t        q[$];
  int         n_vec = 0;
  int         n_err = 0;
  int         last_act = 0;
  int         act_lo = 1;
  int         act_hi = 0;
  logic [7:0] src_m = 8'hFF;
  bit         filled = 1'b0;

  function automatic bit m_active(input int c);
    return (c >= act_lo) && (c <= act_hi);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  task automatic drop_from(input int c);
    ev_t k[$];
    foreach (q[i]) if (q[i].cyc < c) k.push_back(q[i]);
    q = k;
  endtask

  // A start in cycle n: 160 reads from the remapped page and 160 OAM writes.
  task automatic model_start(input int n, input logic [7:0] d);
    int  se;
    ev_t e;
    drop_from(n);
    if (!m_active(n)) act_lo = n + 1;
    act_hi = n + BUSY;
    src_m  = d;
    se = (int'(d) >= 224) ? int'(d) - 32 : int'(d);
    for (int i = 0; i < NBYTES; i++) begin
      e.cyc = n + 1 + SD + i * CPB; e.st = 1'b0;
      e.addr = 16'(se * 256 + i); e.data = 8'h00;
      q.push_back(e);
      e.cyc = n + 2 + SD + i * CPB; e.st = 1'b1;
      e.addr = 16'(65024 + i); e.data = mem_arr[16'(se * 256 + i)];
      q.push_back(e);
    end
  endtask

  task automatic model_reset(input int r);
    drop_from(r);
    if (act_hi >= r) act_hi = r - 1;
    src_m = 8'hFF;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clock4) begin
    ev_t e;
    if (!filled) begin
      for (int i = 0; i < 65536; i++) mem_arr[i] = 8'($urandom);
      for (int i = 0; i < NBYTES; i++) mem_arr[16'(49408 + i)] = 8'(i);
      mem_arr[16'hC000] = 8'h5A;
      filled = 1'b1;
    end
    check("dma_active", dma_active, m_active(cyc));
    if (dma_active) last_act = cyc;
    while (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      n_vec++; n_err++;
      $display("FAIL missed_bus_cycle cyc=%0d got=none exp=%s@%04h cyc%0d",
               cyc, e.st ? "store" : "load", e.addr, e.cyc);
    end
    if (mem_load || mem_store) begin
      if (q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_bus_cycle cyc=%0d got=ld%0b/st%0b@%04h exp=none",
                 cyc, mem_load, mem_store, mem_address);
      end else begin
        e = q.pop_front();
        check("bus_cycle_time", cyc, e.cyc);
        check("bus_kind", {mem_load, mem_store}, {!e.st, e.st});
        check("bus_addr", mem_address, e.addr);
        if (e.st) check("bus_wdata", mem_outdata, e.data);
      end
      if (mem_store) mem_arr[mem_address] = mem_outdata;
    end
  end

  // ---------------- driver ----------------
  task automatic cpu_nop();
    @(posedge clock4); #1;
    cpu_load = 1'b0; cpu_store = 1'b0;
  endtask

  // One CPU access in a single cycle; prediction pushed, same-cycle outputs checked.
  task automatic cpu_op(input bit wr, input logic [15:0] a, input logic [7:0] d);
    bit         is_h, is_r, act;
    logic [7:0] exp;
    ev_t        e;
    @(posedge clock4); #1;
    cpu_address = a; cpu_outdata = d;
    cpu_load = !wr; cpu_store = wr;
    hram_indata = 8'($urandom);
    is_h = (a >= 16'hFF80) && (a <= 16'hFFFE);
    is_r = (a == A_DMA);
    act  = m_active(cyc);
    exp  = is_h ? hram_indata : is_r ? src_m : act ? 8'hFF : mem_arr[a];
    if (!is_h && !is_r && !act) begin
      e.cyc = cyc; e.st = wr; e.addr = a; e.data = wr ? d : 8'h00;
      q.push_back(e);
    end
    if (is_r && wr) model_start(cyc, d);
    @(negedge clock4);
    if (!wr) check("cpu_indata", cpu_indata, exp);
    check("hram_strobes", {hram_load, hram_store}, is_h ? {!wr, wr} : 2'b00);
    if (is_h && wr) begin
      check("hram_address", hram_address, 7'(a - 16'hFF80));
      check("hram_outdata", hram_outdata, d);
    end
  endtask

  task automatic wait_to(input int t);
    while (cyc + 1 < t) cpu_nop();
  endtask

  task automatic wait_idle();
    while (cyc <= act_hi) cpu_nop();
    cpu_nop();
  endtask

  task automatic do_reset();
    @(posedge clock4); #1;
    resetn = 1'b0; cpu_load = 1'b0; cpu_store = 1'b0;
    model_reset(cyc);
    @(negedge clock4);
    check("reset_outputs", {mem_load, mem_store, hram_load, hram_store, dma_active}, 5'b0);
    repeat (2) @(posedge clock4);
    #1 resetn = 1'b1;
  endtask

  function automatic logic [15:0] rand_main();
    logic [15:0] a;
    a = 16'($urandom);
    if (a == A_DMA || (a >= 16'hFF80 && a <= 16'hFFFE)) a = {1'b0, a[14:0]};
    return a;
  endfunction

  initial begin
    int         n, w;
    int         r;
    logic [7:0] d000_old;

    repeat (3) @(posedge clock4);
    #1 resetn = 1'b1;
    @(negedge clock4);
    check("reset_outputs", {mem_load, mem_store, hram_load, hram_store, dma_active}, 5'b0);

    cpu_op(1'b0, A_DMA, 8'h00);
    cpu_op(1'b0, 16'hC000, 8'h00);
    check("c000_mem_load", mem_load, 1'b1);
    check("c000_dma_active", dma_active, 1'b0);
    cpu_nop();

    // Full transfer from C100 with CPU traffic while blocked.
    d000_old = mem_arr[16'hD000];
    cpu_op(1'b1, A_DMA, 8'hC1);
    n = cyc;
    repeat (10) cpu_nop();
    cpu_op(1'b0, 16'h8000, 8'h00);
    cpu_op(1'b1, 16'hD000, 8'h99);
    cpu_op(1'b1, 16'hFF90, 8'h77);
    cpu_nop();
    wait_idle();
    check("busy_length", last_act - n, BUSY);
    for (int i = 0; i < NBYTES; i += 16) check("oam_copy", mem_arr[16'(65024 + i)], i);
    cpu_op(1'b0, 16'hD000, 8'h00);
    check("d000_store_dropped", cpu_indata, d000_old);
    cpu_nop();

    // Echo-region source remaps F3 -> D3.
    cpu_op(1'b1, A_DMA, 8'hF3);
    cpu_nop();
    wait_idle();

    // Restart in the write cycle of byte 50.
    cpu_op(1'b1, A_DMA, 8'hC1);
    n = cyc;
    w = n + 2 + SD + 50 * CPB;
    wait_to(w);
    cpu_op(1'b1, A_DMA, 8'hC2);
    cpu_nop();
    wait_idle();
    check("restart_busy_length", last_act - w, BUSY);

    // Reset pulse during byte 80.
    cpu_op(1'b1, A_DMA, 8'hC3);
    n = cyc;
    wait_to(n + 1 + SD + 80 * CPB);
    do_reset();
    cpu_op(1'b0, A_DMA, 8'h00);
    repeat (20) cpu_nop();

    // Randomized traffic with occasional (re)starts.
    for (int k = 0; k < 2500; k++) begin
      r = int'($urandom_range(0, 999));
      if (r < 400)      cpu_nop();
      else if (r < 550) cpu_op(1'b0, rand_main(), 8'h00);
      else if (r < 650) cpu_op(1'b1, rand_main(), 8'($urandom));
      else if (r < 750) cpu_op(1'b0, 16'(16'hFF80 + $urandom_range(0, 126)), 8'h00);
      else if (r < 850) cpu_op(1'b1, 16'(16'hFF80 + $urandom_range(0, 126)), 8'($urandom));
      else if (r < 994) cpu_op(1'b0, A_DMA, 8'h00);
      else              cpu_op(1'b1, A_DMA, 8'($urandom));
    end
    cpu_nop();
    wait_idle();
    repeat (4) cpu_nop();
    check("scoreboard_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
